// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential fetch, stall, jump,
// taken branch, exception and halt/resume, plus IF/ID flush pulses.
module pc_sequencer #(
    parameter int           AW        = 30,
    parameter logic [AW-1:0] RESET_VEC = 30'h0000_0000,
    parameter logic [AW-1:0] EXC_VEC   = 30'h0000_0020,
    parameter int           CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jmp_valid,
    input  logic [AW-1:0]    jmp_target,
    input  logic             br_taken,
    input  logic [AW-1:0]    br_target,
    input  logic             exc,
    input  logic             halt_req,
    input  logic             resume,
    output logic [AW-1:0]    pc_next,
    output logic [AW-1:0]    pc_cur,
    output logic             fetch_valid,
    output logic             flush_if,
    output logic             flush_id,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               redirect_d;
    logic [AW-1:0]      pc_inc;

    assign pc_inc = pc_q + AW'(1);

    always_comb begin
        state_d    = state_q;
        pc_next    = pc_q;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        redirect_d = 1'b0;
        case (state_q)
            BOOT: begin
                pc_next = RESET_VEC;
                state_d = RUN;
            end
            RUN: begin
                // Redirects are checked before stall so a target is never lost.
                if (exc) begin
                    pc_next    = EXC_VEC;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    redirect_d = 1'b1;
                    state_d    = FLUSH;
                end else if (br_taken) begin
                    pc_next    = br_target;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    redirect_d = 1'b1;
                    state_d    = FLUSH;
                end else if (jmp_valid) begin
                    pc_next    = jmp_target;
                    flush_if   = 1'b1;
                    redirect_d = 1'b1;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (!stall) begin
                    pc_next = pc_inc;
                end
            end
            FLUSH: begin
                // Branch/jump requests here come from squashed instructions.
                if (exc) begin
                    pc_next    = EXC_VEC;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    redirect_d = 1'b1;
                end else begin
                    state_d = RUN;
                    if (!stall) begin
                        pc_next = pc_inc;
                    end
                end
            end
            HALT: begin
                if (exc) begin
                    pc_next    = EXC_VEC;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    redirect_d = 1'b1;
                    state_d    = FLUSH;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                pc_next = RESET_VEC;
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_next;
            if (redirect_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_cur       = pc_q;
    assign fetch_valid  = (state_q == RUN) || (state_q == FLUSH);
    assign halted       = (state_q == HALT);
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: every expected value is hand-computed
// from the intended fetch sequence.
module tb_pc_sequencer;

    localparam int AW    = 30;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall, jmp_valid, br_taken, exc, halt_req, resume;
    logic [AW-1:0]    jmp_target, br_target;
    logic [AW-1:0]    pc_next, pc_cur;
    logic             fetch_valid, flush_if, flush_id, halted;
    logic [CNT_W-1:0] redirect_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(
        .AW(AW), .RESET_VEC(30'h0), .EXC_VEC(30'h20), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .br_taken(br_taken), .br_target(br_target),
        .exc(exc), .halt_req(halt_req), .resume(resume),
        .pc_next(pc_next), .pc_cur(pc_cur), .fetch_valid(fetch_valid),
        .flush_if(flush_if), .flush_id(flush_id), .halted(halted),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, obs);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        stall = 0; jmp_valid = 0; br_taken = 0; exc = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        reset = 0;
        clear_req();
        jmp_target = '0;
        br_target  = '0;
        // Requests during reset must have no effect.
        exc = 1; jmp_valid = 1; jmp_target = 30'h55;
        next_cyc();
        next_cyc();
        @(negedge clk);
        check_val("rst_pc_cur", 32'(pc_cur), 32'h0);
        check_val("rst_pc_next", 32'(pc_next), 32'h0);
        check_val("rst_cnt", 32'(redirect_cnt), 32'h0);
        check_val("rst_fv", 32'(fetch_valid), 32'h0);
        check_val("rst_halted", 32'(halted), 32'h0);
        check_val("rst_flush", 32'({flush_if, flush_id}), 32'h0);

        // Release reset mid-cycle: one BOOT cycle follows.
        clear_req();
        reset = 1;
        #1;
        check_val("boot_pc_cur", 32'(pc_cur), 32'h0);
        check_val("boot_fv", 32'(fetch_valid), 32'h0);
        next_cyc();

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("seq_pc_%0d", k), 32'(pc_cur), 32'(k));
            check_val($sformatf("seq_fv_%0d", k), 32'(fetch_valid), 32'h1);
            next_cyc();
        end
        next_cyc();

        // Stall two cycles at pc 5.
        @(negedge clk);
        check_val("stall_pc0", 32'(pc_cur), 32'h5);
        stall = 1;
        #1;
        check_val("stall_pcnext", 32'(pc_next), 32'h5);
        check_val("stall_flush0", 32'({flush_if, flush_id}), 32'h0);
        next_cyc();
        @(negedge clk);
        check_val("stall_pc1", 32'(pc_cur), 32'h5);
        check_val("stall_flush1", 32'({flush_if, flush_id}), 32'h0);
        next_cyc();
        @(negedge clk);
        check_val("stall_pc2", 32'(pc_cur), 32'h5);
        stall = 0;
        next_cyc();
        @(negedge clk);
        check_val("stall_pc3", 32'(pc_cur), 32'h6);
        next_cyc();
        next_cyc();

        // Branch and jump together at pc 8: branch wins.
        @(negedge clk);
        check_val("brj_pc", 32'(pc_cur), 32'h8);
        jmp_valid = 1; jmp_target = 30'h40;
        br_taken  = 1; br_target  = 30'h100;
        #1;
        check_val("brj_pc_next", 32'(pc_next), 32'h100);
        check_val("brj_flush", 32'({flush_if, flush_id}), 32'h3);
        next_cyc();
        jmp_valid = 0;
        br_target = 30'h200;
        @(negedge clk);
        check_val("flush_pc", 32'(pc_cur), 32'h100);
        check_val("flush_fv", 32'(fetch_valid), 32'h1);
        check_val("flush_br_ignored", 32'(pc_next), 32'h101);
        check_val("flush_noflush", 32'({flush_if, flush_id}), 32'h0);
        check_val("flush_cnt", 32'(redirect_cnt), 32'h1);
        next_cyc();
        br_taken = 0;
        @(negedge clk);
        check_val("flush_pc2", 32'(pc_cur), 32'h101);

        // Jump to 12, then jump to 4 under stall.
        jmp_valid = 1; jmp_target = 30'd12;
        #1;
        check_val("jmp12_flush", 32'({flush_if, flush_id}), 32'h2);
        next_cyc();
        @(negedge clk);
        check_val("jmp12_pc", 32'(pc_cur), 32'd12);
        jmp_target = 30'd4; stall = 1;
        #1;
        check_val("jmpstall_pc_next", 32'(pc_next), 32'd4);
        check_val("jmpstall_flush", 32'({flush_if, flush_id}), 32'h2);
        next_cyc();
        clear_req();
        @(negedge clk);
        check_val("jmpstall_pc", 32'(pc_cur), 32'd4);
        check_val("jmpstall_cnt", 32'(redirect_cnt), 32'd3);
        // Still in RUN: a branch is honoured here (it would be ignored in FLUSH).
        br_taken = 1; br_target = 30'h30;
        #1;
        check_val("jmp_stays_run", 32'(pc_next), 32'h30);
        next_cyc();
        clear_req();
        next_cyc();
        jmp_valid = 1; jmp_target = 30'd7;
        next_cyc();
        clear_req();

        // Halt at pc 7 for 3 cycles, then resume.
        @(negedge clk);
        check_val("halt_pc", 32'(pc_cur), 32'd7);
        check_val("halt_cnt", 32'(redirect_cnt), 32'd5);
        halt_req = 1;
        #1;
        check_val("halt_pc_next", 32'(pc_next), 32'd7);
        next_cyc();
        halt_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val($sformatf("halted_%0d", k), 32'(halted), 32'h1);
            check_val($sformatf("halt_fv_%0d", k), 32'(fetch_valid), 32'h0);
            check_val($sformatf("halt_pc_%0d", k), 32'(pc_cur), 32'd7);
            if (k == 1) begin
                jmp_valid = 1; jmp_target = 30'h55; stall = 1;
                #1;
                check_val("halt_jmp_ignored", 32'(pc_next), 32'd7);
                check_val("halt_noflush", 32'({flush_if, flush_id}), 32'h0);
            end
            if (k == 2) begin
                clear_req();
                resume = 1;
                #1;
                check_val("resume_pc_next", 32'(pc_next), 32'd7);
            end
            next_cyc();
        end
        resume = 0;
        @(negedge clk);
        check_val("resume_pc", 32'(pc_cur), 32'd7);
        check_val("resume_fv", 32'(fetch_valid), 32'h1);
        check_val("resume_halted", 32'(halted), 32'h0);
        next_cyc();
        @(negedge clk);
        check_val("resume_pc2", 32'(pc_cur), 32'd8);

        // Halt again; exception beats resume.
        halt_req = 1;
        next_cyc();
        halt_req = 0;
        @(negedge clk);
        check_val("halt2", 32'(halted), 32'h1);
        exc = 1; resume = 1;
        #1;
        check_val("hexc_pc_next", 32'(pc_next), 32'h20);
        check_val("hexc_flush", 32'({flush_if, flush_id}), 32'h3);
        next_cyc();
        clear_req();
        @(negedge clk);
        check_val("hexc_pc", 32'(pc_cur), 32'h20);
        check_val("hexc_fv", 32'(fetch_valid), 32'h1);
        check_val("hexc_cnt", 32'(redirect_cnt), 32'd6);
        br_taken = 1; br_target = 30'h99;
        #1;
        check_val("hexc_br_ignored", 32'(pc_next), 32'h21);
        exc = 1;
        #1;
        check_val("fexc_pc_next", 32'(pc_next), 32'h20);
        check_val("fexc_flush", 32'({flush_if, flush_id}), 32'h3);
        next_cyc();
        exc = 0;
        @(negedge clk);
        check_val("fexc_pc", 32'(pc_cur), 32'h20);
        check_val("fexc_stays_flush", 32'(pc_next), 32'h21);
        check_val("fexc_cnt", 32'(redirect_cnt), 32'd7);
        next_cyc();
        clear_req();

        // Wrap-around at the top of the address space.
        jmp_valid = 1; jmp_target = 30'h3FFF_FFFF;
        next_cyc();
        clear_req();
        @(negedge clk);
        check_val("wrap_top", 32'(pc_cur), 32'h3FFF_FFFF);
        check_val("wrap_pc_next", 32'(pc_next), 32'h0);
        next_cyc();
        check_val("wrap_pc", 32'(pc_cur), 32'h0);

        // 300 back-to-back jumps saturate the counter (starting from 8).
        jmp_valid = 1; jmp_target = 30'h1234;
        for (int i = 0; i < 300; i++) begin
            next_cyc();
            if (i == 245) check_val("sat_254", 32'(redirect_cnt), 32'd254);
            if (i == 246) check_val("sat_255", 32'(redirect_cnt), 32'd255);
        end
        check_val("sat_final", 32'(redirect_cnt), 32'd255);
        clear_req();
        next_cyc();
        next_cyc();
        check_val("pre_rst_pc", 32'(pc_cur), 32'h1236);

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        #2;
        reset = 0;
        #1;
        check_val("async_rst_pc", 32'(pc_cur), 32'h0);
        check_val("async_rst_cnt", 32'(redirect_cnt), 32'h0);
        check_val("async_rst_fv", 32'(fetch_valid), 32'h0);
        @(negedge clk);
        reset = 1;
        next_cyc();
        @(negedge clk);
        check_val("rerun_pc0", 32'(pc_cur), 32'h0);
        check_val("rerun_fv", 32'(fetch_valid), 32'h1);
        next_cyc();
        check_val("rerun_pc1", 32'(pc_cur), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
